// File: rtl/sobel_gradient_pipe_if.sv
// sobel_gradient_pipe_if: window-in / magnitude-out valid-ready bundle for the Sobel pipe
interface sobel_gradient_pipe_if #(
    parameter int PIX_W = 8
);
    logic               i_valid;
    logic               o_ready;
    logic [9*PIX_W-1:0] i_window;
    logic [1:0]         i_mode;
    logic [PIX_W-1:0]   i_thresh;
    logic               o_valid;
    logic               i_ready;
    logic [PIX_W-1:0]   o_data;
    logic               o_sat;
    modport slave (
        input  i_valid, i_window, i_mode, i_thresh, i_ready,
        output o_ready, o_valid, o_data, o_sat
    );
    modport master (
        output i_valid, i_window, i_mode, i_thresh, i_ready,
        input  o_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/sobel_gradient_pipe.sv
// sobel_gradient_pipe: pipelined 3x3 Sobel magnitude with L1/max/threshold modes and full backpressure
module sobel_gradient_pipe #(
    parameter int PIX_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    sobel_gradient_pipe_if.slave bus
);
    localparam int DW = PIX_W + 1;
    localparam int GW = PIX_W + 3;
    localparam int AW = PIX_W + 2;
    localparam logic [PIX_W-1:0] MAXV = '1;
    logic                 adv;
    logic [3:0]           v;
    logic [1:0]           md [4];
    logic [PIX_W-1:0]     th [4];
    logic [9*PIX_W-1:0]   win;
    logic [PIX_W-1:0]     p [9];
    logic signed [DW-1:0] df [6];
    logic signed [GW-1:0] gx, gy;
    logic [AW-1:0]        ax, ay, m;
    logic [GW-1:0]        l1;
    logic [PIX_W-1:0]     l1_sat, m_sat;
    logic                 l1_ov, m_ov;
    assign adv = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = adv && !rst;
    for (genvar g = 0; g < 9; g++) begin : g_pix
        assign p[g] = win[g*PIX_W +: PIX_W];
    end
    function automatic logic signed [DW-1:0] sub(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction
    always_comb begin
        l1     = GW'(ax) + GW'(ay);
        m      = ax > ay ? ax : ay;
        l1_ov  = l1 > GW'(MAXV);
        m_ov   = m > AW'(MAXV);
        l1_sat = l1_ov ? MAXV : l1[PIX_W-1:0];
        m_sat  = m_ov ? MAXV : m[PIX_W-1:0];
    end
    // Valid bits and the output stage are the only state that reset must clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            v           <= '0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_sat   <= 1'b0;
        end else if (adv) begin
            v           <= {v[2:0], bus.i_valid};
            bus.o_valid <= v[3];
            bus.o_data  <= md[3] == 2'd1 ? m_sat : md[3] == 2'd2 ? (l1_sat >= th[3] ? MAXV : '0) : l1_sat;
            bus.o_sat   <= md[3] == 2'd1 ? m_ov : l1_ov;
        end
    end
    always_ff @(posedge clk) begin
        if (adv) begin
            win   <= bus.i_window;
            md[0] <= bus.i_mode;
            th[0] <= bus.i_thresh;
            for (int k = 1; k < 4; k++) begin
                md[k] <= md[k-1];
                th[k] <= th[k-1];
            end
            df[0] <= sub(p[2], p[0]);
            df[1] <= sub(p[5], p[3]);
            df[2] <= sub(p[8], p[6]);
            df[3] <= sub(p[0], p[6]);
            df[4] <= sub(p[1], p[7]);
            df[5] <= sub(p[2], p[8]);
            gx    <= GW'(df[0]) + GW'(df[1]) + GW'(df[1]) + GW'(df[2]);
            gy    <= GW'(df[3]) + GW'(df[4]) + GW'(df[4]) + GW'(df[5]);
            ax    <= AW'(gx[GW-1] ? -gx : gx);
            ay    <= AW'(gy[GW-1] ? -gy : gy);
        end
    end
endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// tb_sobel_gradient_pipe: directed and random checks of the Sobel pipe against an integer model
module tb_sobel_gradient_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] q [$];
    logic stall_prev = 1'b0;
    logic [7:0] pd;
    logic ps;
    logic [95:0] r;
    int i, cyc;
    logic acc;

    sobel_gradient_pipe_if #(.PIX_W(8)) bus ();
    sobel_gradient_pipe #(.PIX_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] win(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
        return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    endfunction

    // Returns {sat, data} straight from the Sobel definitions using plain integers.
    function automatic logic [8:0] model(input logic [71:0] w, input logic [1:0] md, input logic [7:0] th);
        int p [9];
        int gx, gy, ax, ay, l1, mx, sl;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
        gx = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
        gy = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
        ax = gx < 0 ? -gx : gx;
        ay = gy < 0 ? -gy : gy;
        l1 = ax + ay;
        mx = ax > ay ? ax : ay;
        sl = l1 > 255 ? 255 : l1;
        if (md == 2'd1) return {mx > 255, 8'(mx > 255 ? 255 : mx)};
        if (md == 2'd2) return {l1 > 255, (sl >= int'(th)) ? 8'hFF : 8'h00};
        return {l1 > 255, 8'(sl)};
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", bus.o_valid, 1);
                chk("stall_data", bus.o_data, pd);
                chk("stall_sat", bus.o_sat, ps);
            end
            if (bus.o_valid && !bus.i_ready) chk("stall_ready", bus.o_ready, 0);
            stall_prev = bus.o_valid && !bus.i_ready;
            pd = bus.o_data;
            ps = bus.o_sat;
            if (bus.o_valid && bus.i_ready) begin
                if (q.size() == 0) chk("unexpected_out", bus.o_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("model_data", bus.o_data, e[7:0]);
                    chk("model_sat", bus.o_sat, e[8]);
                end
            end
            if (bus.i_valid && bus.o_ready) q.push_back(model(bus.i_window, bus.i_mode, bus.i_thresh));
        end
    end

    task automatic run_one(input logic [71:0] w, input logic [1:0] md, input logic [7:0] th,
                           input int exp_d, input int exp_s, input string tag);
        int n;
        bus.i_window = w;
        bus.i_mode = md;
        bus.i_thresh = th;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_data"}, bus.o_data, exp_d);
        chk({tag, "_sat"}, bus.o_sat, exp_s);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_window = '0;
        bus.i_mode = 2'd0;
        bus.i_thresh = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_o_sat", bus.o_sat, 0);
        chk("rst_o_ready", bus.o_ready, 0);
        rst = 1'b0;
        #1 chk("ready_after_rst", bus.o_ready, 1);

        run_one(win(100, 100, 100, 100, 100, 100, 100, 100, 100), 2'd0, 8'd0, 0, 0, "flat");
        run_one(win(0, 0, 255, 0, 0, 255, 0, 0, 255), 2'd0, 8'd0, 255, 1, "vedge_l1");
        run_one(win(0, 0, 255, 0, 0, 255, 0, 0, 255), 2'd1, 8'd0, 255, 1, "vedge_max");
        run_one(win(0, 0, 10, 0, 0, 0, 0, 0, 0), 2'd0, 8'd0, 20, 0, "p2_l1");
        run_one(win(0, 0, 10, 0, 0, 0, 0, 0, 0), 2'd1, 8'd0, 10, 0, "p2_max");
        run_one(win(0, 0, 10, 0, 0, 0, 0, 0, 0), 2'd2, 8'd20, 255, 0, "p2_th20");
        run_one(win(0, 0, 10, 0, 0, 0, 0, 0, 0), 2'd2, 8'd21, 0, 0, "p2_th21");
        run_one(win(10, 0, 0, 0, 0, 0, 0, 0, 0), 2'd0, 8'd0, 20, 0, "p0_l1");
        run_one(win(10, 0, 0, 0, 0, 0, 0, 0, 0), 2'd3, 8'd0, 20, 0, "p0_mode3");

        // Back-to-back random stream with a three-cycle downstream stall in the middle.
        i = 0;
        cyc = 0;
        r = {$urandom(), $urandom(), $urandom()};
        bus.i_window = r[71:0];
        bus.i_mode = 2'd0;
        bus.i_thresh = 8'($urandom());
        bus.i_valid = 1'b1;
        while (i < 8 && cyc < 200) begin
            @(negedge clk);
            acc = bus.i_valid && bus.o_ready;
            @(posedge clk);
            #1 cyc++;
            bus.i_ready = !(cyc >= 5 && cyc < 8);
            if (acc) begin
                i++;
                if (i < 8) begin
                    r = {$urandom(), $urandom(), $urandom()};
                    bus.i_window = r[71:0];
                    bus.i_mode = 2'(i % 4);
                    bus.i_thresh = 8'($urandom());
                end else bus.i_valid = 1'b0;
            end
        end
        chk("stream_accepts", i, 8);
        bus.i_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("stream_drained", q.size(), 0);

        // Three samples in flight, then a one-cycle reset must discard them all.
        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom(), $urandom()};
            bus.i_window = r[71:0];
            bus.i_mode = 2'(k);
            bus.i_thresh = 8'($urandom());
            bus.i_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_o_valid", bus.o_valid, 0);
        chk("midrst_o_data", bus.o_data, 0);
        chk("midrst_o_sat", bus.o_sat, 0);
        run_one(win(0, 0, 10, 0, 0, 0, 0, 0, 0), 2'd0, 8'd0, 20, 0, "post_rst");
        repeat (10) @(posedge clk);
        #1 chk("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "timeout");
    end
endmodule
